mul_twf_pipe: RTL and testbench

//   Parametrised radix-2 twiddle multiplier stage for the pipelined FFT: LANES parallel complex
//   add/sub sample pairs are multiplied by per-lane twiddles. Two-stage pipeline with valid/ready

---
 rtl/mul_twf_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_mul_twf_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_twf_pipe.sv
// Radix-2 twiddle multiplier stage: LANES complex add/sub pairs times per-lane twiddles.
// Two-stage valid/ready pipeline with twiddle address sequencer, conjugate/bypass modes, round+saturate.
module mul_twf_pipe #(
  parameter int LANES     = 8,
  parameter int DIN_W     = 16,
  parameter int TWF_W     = 9,
  parameter int DOUT_W    = 25,
  parameter int SHIFT     = 0,
  parameter int ADDR_W    = 9,
  parameter int ADDR_LAST = 504
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sof,
  input  logic                           conj,
  input  logic                           bypass,
  input  logic [LANES-1:0][DIN_W-1:0]    din_R_add,
  input  logic [LANES-1:0][DIN_W-1:0]    din_Q_add,
  input  logic [LANES-1:0][DIN_W-1:0]    din_R_sub,
  input  logic [LANES-1:0][DIN_W-1:0]    din_Q_sub,
  output logic [ADDR_W-1:0]              tw_addr,
  input  logic [LANES-1:0][TWF_W-1:0]    twf_R_add,
  input  logic [LANES-1:0][TWF_W-1:0]    twf_Q_add,
  input  logic [LANES-1:0][TWF_W-1:0]    twf_R_sub,
  input  logic [LANES-1:0][TWF_W-1:0]    twf_Q_sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0][DOUT_W-1:0]   dout_R_add,
  output logic [LANES-1:0][DOUT_W-1:0]   dout_Q_add,
  output logic [LANES-1:0][DOUT_W-1:0]   dout_R_sub,
  output logic [LANES-1:0][DOUT_W-1:0]   dout_Q_sub,
  output logic                           sat_flag
);

  localparam int PW  = DIN_W + TWF_W;
  localparam int SW  = PW + 2;
  localparam int EW  = ((SW > DOUT_W) ? SW : DOUT_W) + 1;
  localparam int RND = (1 << SHIFT) >> 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  logic                         w_stall;
  logic                         w_accept;
  logic                         r_v1;
  logic                         r_v2;
  logic                         r_sat;
  logic [ADDR_W-1:0]            r_cnt;

  logic [DIN_W-1:0]             w_r   [2][LANES];
  logic [DIN_W-1:0]             w_q   [2][LANES];
  logic [TWF_W-1:0]             w_wr  [2][LANES];
  logic [TWF_W-1:0]             w_wq  [2][LANES];
  logic signed [PW-1:0]         w_prr [2][LANES];
  logic signed [PW-1:0]         w_pqq [2][LANES];
  logic signed [PW-1:0]         w_pqr [2][LANES];
  logic signed [PW-1:0]         w_prq [2][LANES];
  logic signed [PW-1:0]         r_prr [2][LANES];
  logic signed [PW-1:0]         r_pqq [2][LANES];
  logic signed [PW-1:0]         r_pqr [2][LANES];
  logic signed [PW-1:0]         r_prq [2][LANES];
  logic [DOUT_W:0]              w_tre [2][LANES];
  logic [DOUT_W:0]              w_tim [2][LANES];
  logic [LANES-1:0][DOUT_W-1:0] w_re  [2];
  logic [LANES-1:0][DOUT_W-1:0] w_im  [2];
  logic [LANES-1:0][DOUT_W-1:0] r_re  [2];
  logic [LANES-1:0][DOUT_W-1:0] r_im  [2];
  logic                         w_sat;

  // Operands are sign-extended to the product width so the low PW bits of an unsigned multiply are exact.
  function automatic logic signed [PW-1:0] mul_w(input logic [DIN_W-1:0] a, input logic [TWF_W:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{(PW-DIN_W){a[DIN_W-1]}}, a};
    bx = {{(PW-TWF_W-1){b[TWF_W]}}, b};
    return ax * bx;
  endfunction

  // One extra bit so negating -2^(TWF_W-1) under conj does not wrap.
  function automatic logic [TWF_W:0] tw_ext(input logic [TWF_W-1:0] w, input logic neg);
    logic [TWF_W:0] x;
    x = {w[TWF_W-1], w};
    return neg ? -x : x;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [DOUT_W:0] rnd_sat(input logic signed [PW-1:0] a,
                                              input logic signed [PW-1:0] b,
                                              input logic sub);
    logic signed [SW-1:0] s;
    logic signed [EW-1:0] e;
    s = sub ? (SW'(a) - SW'(b)) : (SW'(a) + SW'(b));
    s = s + SW'(RND);
    s = s >>> SHIFT;
    e = EW'(s);
    if (e > MAXV)      return {1'b1, MAXV[DOUT_W-1:0]};
    else if (e < MINV) return {1'b1, MINV[DOUT_W-1:0]};
    else               return {1'b0, e[DOUT_W-1:0]};
  endfunction

  assign out_valid = r_v2;
  assign w_stall   = r_v2 & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_accept  = in_valid & ~w_stall;
  assign tw_addr   = sof ? '0 : r_cnt;
  assign sat_flag  = r_sat;

  assign dout_R_add = r_re[0];
  assign dout_Q_add = r_im[0];
  assign dout_R_sub = r_re[1];
  assign dout_Q_sub = r_im[1];

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_r[0][j]  = din_R_add[j];
      w_q[0][j]  = din_Q_add[j];
      w_r[1][j]  = din_R_sub[j];
      w_q[1][j]  = din_Q_sub[j];
      w_wr[0][j] = twf_R_add[j];
      w_wq[0][j] = twf_Q_add[j];
      w_wr[1][j] = twf_R_sub[j];
      w_wq[1][j] = twf_Q_sub[j];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < LANES; j++) begin
        if (bypass) begin
          w_prr[p][j] = {w_r[p][j][DIN_W-1], w_r[p][j], {(TWF_W-1){1'b0}}};
          w_pqr[p][j] = {w_q[p][j][DIN_W-1], w_q[p][j], {(TWF_W-1){1'b0}}};
          w_pqq[p][j] = '0;
          w_prq[p][j] = '0;
        end else begin
          w_prr[p][j] = mul_w(w_r[p][j], tw_ext(w_wr[p][j], 1'b0));
          w_pqr[p][j] = mul_w(w_q[p][j], tw_ext(w_wr[p][j], 1'b0));
          w_pqq[p][j] = mul_w(w_q[p][j], tw_ext(w_wq[p][j], conj));
          w_prq[p][j] = mul_w(w_r[p][j], tw_ext(w_wq[p][j], conj));
        end
      end
    end
  end

  always_comb begin
    w_sat = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < LANES; j++) begin
        w_tre[p][j] = rnd_sat(r_prr[p][j], r_pqq[p][j], 1'b1);
        w_tim[p][j] = rnd_sat(r_pqr[p][j], r_prq[p][j], 1'b0);
        w_re[p][j]  = w_tre[p][j][DOUT_W-1:0];
        w_im[p][j]  = w_tim[p][j][DOUT_W-1:0];
        w_sat       = w_sat | w_tre[p][j][DOUT_W] | w_tim[p][j][DOUT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (tw_addr == ADDR_W'(ADDR_LAST)) ? '0 : tw_addr + ADDR_W'(LANES);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int j = 0; j < LANES; j++) begin
          r_prr[p][j] <= '0;
          r_pqq[p][j] <= '0;
          r_pqr[p][j] <= '0;
          r_prq[p][j] <= '0;
        end
      end
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_prr <= w_prr;
        r_pqq <= w_pqq;
        r_pqr <= w_pqr;
        r_prq <= w_prq;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2  <= 1'b0;
      r_sat <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        r_re[p] <= '0;
        r_im[p] <= '0;
      end
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_re <= w_re;
        r_im <= w_im;
        if (w_sat) r_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_twf_pipe.sv
// Bench for mul_twf_pipe: directed vector table, stall/latency sequence, address sequencing,
// and a randomised backpressure run against a reference complex-multiply model.
module tb_mul_twf_pipe;
  localparam int LANES = 8, DIN_W = 16, TWF_W = 9, DOUT_W = 25, SHIFT = 0, ADDR_W = 9, ADDR_LAST = 504;

  typedef logic [LANES-1:0][DIN_W-1:0]  din_t;
  typedef logic [LANES-1:0][TWF_W-1:0]  twf_t;
  typedef logic [LANES-1:0][DOUT_W-1:0] dout_t;
  typedef struct { int r; int q; int wr; int wq; bit cj; bit bp; int re; int im; bit sat; } vec_t;
  typedef struct { dout_t ra; dout_t qa; dout_t rs; dout_t qs; } beat_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_ready, sof = 1'b0, conj = 1'b0, bypass = 1'b0;
  din_t din_R_add = '0, din_Q_add = '0, din_R_sub = '0, din_Q_sub = '0;
  twf_t twf_R_add = '0, twf_Q_add = '0, twf_R_sub = '0, twf_Q_sub = '0;
  logic [ADDR_W-1:0] tw_addr;
  logic out_valid, out_ready = 1'b1, sat_flag;
  dout_t dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub;

  int n_tests = 0, n_fail = 0;
  vec_t vt[8];
  beat_t exp_q[$];

  mul_twf_pipe #(.LANES(LANES), .DIN_W(DIN_W), .TWF_W(TWF_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT),
                 .ADDR_W(ADDR_W), .ADDR_LAST(ADDR_LAST)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .sof(sof), .conj(conj),
    .bypass(bypass), .din_R_add(din_R_add), .din_Q_add(din_Q_add), .din_R_sub(din_R_sub),
    .din_Q_sub(din_Q_sub), .tw_addr(tw_addr), .twf_R_add(twf_R_add), .twf_Q_add(twf_Q_add),
    .twf_R_sub(twf_R_sub), .twf_Q_sub(twf_Q_sub), .out_valid(out_valid), .out_ready(out_ready),
    .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add), .dout_R_sub(dout_R_sub),
    .dout_Q_sub(dout_Q_sub), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int re, input int im);
    int bad_lane = -1;
    longint a = 0, e = 0;
    for (int j = 0; j < LANES; j++) begin
      if (bad_lane < 0) begin
        if (longint'($signed(dout_R_add[j])) != re) begin bad_lane = j; a = $signed(dout_R_add[j]); e = re; end
        else if (longint'($signed(dout_Q_add[j])) != im) begin bad_lane = j; a = $signed(dout_Q_add[j]); e = im; end
        else if (longint'($signed(dout_R_sub[j])) != re) begin bad_lane = j; a = $signed(dout_R_sub[j]); e = re; end
        else if (longint'($signed(dout_Q_sub[j])) != im) begin bad_lane = j; a = $signed(dout_Q_sub[j]); e = im; end
      end
    end
    n_tests++;
    if (bad_lane >= 0) begin
      n_fail++;
      $display("FAIL %s: lane %0d got %0d, expected %0d", name, bad_lane, a, e);
    end
  endtask

  task automatic drive_all(input int r, input int q, input int wr, input int wq, input bit cj, input bit bp);
    for (int j = 0; j < LANES; j++) begin
      din_R_add[j] = DIN_W'(r);  din_Q_add[j] = DIN_W'(q);
      din_R_sub[j] = DIN_W'(r);  din_Q_sub[j] = DIN_W'(q);
      twf_R_add[j] = TWF_W'(wr); twf_Q_add[j] = TWF_W'(wq);
      twf_R_sub[j] = TWF_W'(wr); twf_Q_sub[j] = TWF_W'(wq);
    end
    conj = cj;
    bypass = bp;
  endtask

  function automatic void cmul(input longint r, input longint q, input longint wr, input longint wq,
                               input bit cj, input bit bp, output longint re, output longint im);
    longint lim;
    lim = longint'(1) << (DOUT_W - 1);
    if (bp) begin
      wr = longint'(1) << (TWF_W - 1);
      wq = 0;
    end else if (cj) begin
      wq = -wq;
    end
    re = r * wr - q * wq;
    im = q * wr + r * wq;
    if (re > lim - 1) re = lim - 1;
    if (re < -lim)    re = -lim;
    if (im > lim - 1) im = lim - 1;
    if (im < -lim)    im = -lim;
  endfunction

  task automatic push_model();
    beat_t b;
    longint re, im;
    for (int j = 0; j < LANES; j++) begin
      cmul($signed(din_R_add[j]), $signed(din_Q_add[j]), $signed(twf_R_add[j]), $signed(twf_Q_add[j]),
           conj, bypass, re, im);
      b.ra[j] = re[DOUT_W-1:0];
      b.qa[j] = im[DOUT_W-1:0];
      cmul($signed(din_R_sub[j]), $signed(din_Q_sub[j]), $signed(twf_R_sub[j]), $signed(twf_Q_sub[j]),
           conj, bypass, re, im);
      b.rs[j] = re[DOUT_W-1:0];
      b.qs[j] = im[DOUT_W-1:0];
    end
    exp_q.push_back(b);
  endtask

  task automatic pop_check();
    beat_t b;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL stream_extra: got an output beat, expected none queued");
    end else begin
      b = exp_q.pop_front();
      if ({dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub} !== {b.ra, b.qa, b.rs, b.qs}) begin
        n_fail++;
        $display("FAIL stream_data: lane0 got R=%0d Q=%0d, expected R=%0d Q=%0d",
                 $signed(dout_R_add[0]), $signed(dout_Q_add[0]), $signed(b.ra[0]), $signed(b.qa[0]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit lat_ok, was_stalled;
    dout_t s_ra, s_qa, s_rs, s_qs;

    vt[0] = '{r: 1000,   q: -7,     wr: 0,    wq: 0,    cj: 0, bp: 1, re: 256000,   im: -1792,   sat: 0};
    vt[1] = '{r: 100,    q: 50,     wr: 181,  wq: -181, cj: 0, bp: 0, re: 27150,    im: -9050,   sat: 0};
    vt[2] = '{r: 100,    q: 50,     wr: 181,  wq: -181, cj: 1, bp: 0, re: 9050,     im: 27150,   sat: 0};
    vt[3] = '{r: -5,     q: 3,      wr: 0,    wq: 255,  cj: 0, bp: 0, re: -765,     im: -1275,   sat: 0};
    vt[4] = '{r: -300,   q: -400,   wr: -100, wq: 200,  cj: 0, bp: 0, re: 110000,   im: -20000,  sat: 0};
    vt[5] = '{r: -32768, q: 32767,  wr: -5,   wq: 77,   cj: 1, bp: 1, re: -8388608, im: 8388352, sat: 0};
    vt[6] = '{r: -32768, q: -32768, wr: -256, wq: -256, cj: 1, bp: 0, re: 16777215, im: 0,       sat: 1};
    vt[7] = '{r: 0,      q: 0,      wr: 17,   wq: 3,    cj: 0, bp: 0, re: 0,        im: 0,       sat: 1};

    // reset state
    rstn = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_tw_addr", tw_addr, 0);
    check("rst_dout", longint'($signed(dout_R_add[3])), 0);
    rstn = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // directed vector table: latency, value, bubble, sticky saturation
    for (int i = 0; i < 8; i++) begin
      drive_all(vt[i].r, vt[i].q, vt[i].wr, vt[i].wq, vt[i].cj, vt[i].bp);
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat_ok = (out_valid == 1'b0);
      step();
      check($sformatf("vec%0d_latency", i), (lat_ok && out_valid) ? 1 : 0, 1);
      check_all($sformatf("vec%0d_data", i), vt[i].re, vt[i].im);
      check($sformatf("vec%0d_sat", i), sat_flag, vt[i].sat);
      step();
      check($sformatf("vec%0d_bubble", i), out_valid, 0);
    end

    // backpressure: hold, refuse input while stalled, then drain in order
    out_ready = 1'b0;
    drive_all(1000, -7, 0, 0, 0, 1);
    in_valid = 1'b1;
    step();
    drive_all(100, 50, 181, -181, 0, 0);
    check("stall_ready_before", in_ready, 1);
    step();
    check("stall_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    drive_all(100, 50, 181, -181, 1, 0);
    step();
    check("stall_hold_valid", out_valid, 1);
    check_all("stall_hold_data", 256000, -1792);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_all("stall_beat_b", 27150, -9050);
    step();
    check("stall_beat_c_valid", out_valid, 1);
    check_all("stall_beat_c", 9050, 27150);
    step();
    check("stall_drained", out_valid, 0);

    // address sequencing over a full frame and wrap
    in_valid = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      sof = (i == 0);
      #1;
      check($sformatf("addr_frame_%0d", i), tw_addr, (i * 8) % 512);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      sof = (i == 0) || (i == 10);
      #1;
      check($sformatf("addr_sof_%0d", i), tw_addr, (i < 10) ? i * 8 : (i - 10) * 8);
      step();
    end
    sof = 1'b0;
    in_valid = 1'b0;
    step(); step(); step();
    check("addr_hold_idle", tw_addr, 48);
    sof = 1'b1;
    #1;
    check("addr_sof_idle", tw_addr, 0);
    sof = 1'b0;
    step(); step();

    // randomised stream with backpressure and a mid-stream reset
    exp_q.delete();
    was_stalled = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat", sat_flag, 0);
        step();
        rstn = 1'b1;
        in_valid = 1'b0;
        sof = 1'b0;
        exp_q.delete();
        was_stalled = 1'b0;
        #1;
        check("midrst_tw_addr", tw_addr, 0);
        step();
      end
      if (was_stalled) begin
        n_tests++;
        if (!out_valid || {dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub} !== {s_ra, s_qa, s_rs, s_qs}) begin
          n_fail++;
          $display("FAIL stall_stable: valid=%0d lane0 R=%0d, expected valid=1 R=%0d",
                   out_valid, $signed(dout_R_add[0]), $signed(s_ra[0]));
        end
      end
      out_ready = ($urandom % 2) == 0;
      in_valid  = ($urandom % 3) != 0;
      sof       = ($urandom % 32) == 0;
      conj      = $urandom % 2;
      bypass    = ($urandom % 4) == 0;
      for (int j = 0; j < LANES; j++) begin
        din_R_add[j] = DIN_W'($urandom); din_Q_add[j] = DIN_W'($urandom);
        din_R_sub[j] = DIN_W'($urandom); din_Q_sub[j] = DIN_W'($urandom);
        twf_R_add[j] = TWF_W'($urandom); twf_Q_add[j] = TWF_W'($urandom);
        twf_R_sub[j] = TWF_W'($urandom); twf_Q_sub[j] = TWF_W'($urandom);
      end
      #1;
      if (out_valid && out_ready) pop_check();
      if (in_valid && in_ready) push_model();
      was_stalled = out_valid && !out_ready;
      s_ra = dout_R_add; s_qa = dout_Q_add; s_rs = dout_R_sub; s_qs = dout_Q_sub;
      step();
    end
    in_valid = 1'b0;
    sof = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid) pop_check();
      step();
    end
    check("stream_all_delivered", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
